// File: rtl/alu_result_checker_if.sv
// Issue/response bundle between a CPU-side driver and the ALU result checker.
// The master drives the issued operation and the CPU response; the slave returns issue_ready.
interface alu_result_checker_if;
    logic       issue_valid;
    logic [3:0] issue_op;
    logic [7:0] issue_a;
    logic [7:0] issue_b;
    logic       issue_ready;

    logic       rsp_valid;
    logic [7:0] rsp_result;
    logic       rsp_zero;
    logic       rsp_neg;
    logic       rsp_carry;
    logic       rsp_ovf;

    modport master (
        output issue_valid, issue_op, issue_a, issue_b,
        input  issue_ready,
        output rsp_valid, rsp_result, rsp_zero, rsp_neg, rsp_carry, rsp_ovf
    );

    modport slave (
        input  issue_valid, issue_op, issue_a, issue_b,
        output issue_ready,
        input  rsp_valid, rsp_result, rsp_zero, rsp_neg, rsp_carry, rsp_ovf
    );
endinterface

// File: rtl/alu_result_checker.sv
// Records issued ALU operations in a FIFO and checks each CPU response against a golden model.
// Optional first-fail capture enabled by defining CHK_FIRST_FAIL_EN.
module alu_result_checker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_result_checker_if.slave      bus,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic                     err_sticky,
    output logic                     orphan,
    output logic [$clog2(DEPTH):0]   pend_cnt,
    output logic                     ff_valid,
    output logic [3:0]               ff_op,
    output logic [7:0]               ff_exp,
    output logic [7:0]               ff_got
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] L_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] L_ONE  = (PW+1)'(1);

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_SLT = 4'h5,
        OP_SLL = 4'h6,
        OP_SRL = 4'h7
    } op_e;

    logic [3:0]       r_mem_op [DEPTH];
    logic [7:0]       r_mem_a  [DEPTH];
    logic [7:0]       r_mem_b  [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_pend_cnt;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_err_sticky;
    logic             r_orphan;

    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_orphan_evt;
    logic             w_match;
    logic             w_pass;
    logic             w_fail;
    logic [3:0]       w_head_op;
    logic [7:0]       w_head_a;
    logic [7:0]       w_head_b;
    logic [8:0]       w_sum9;
    logic [7:0]       w_exp_r;
    logic             w_exp_z;
    logic             w_exp_n;
    logic             w_exp_c;
    logic             w_exp_v;

    // Ready depends only on registered occupancy, so a pop in a full cycle frees the slot next cycle.
    assign w_ready         = (r_pend_cnt != L_FULL);
    assign bus.issue_ready = w_ready;
    assign w_push          = bus.issue_valid && w_ready;
    assign w_pop           = bus.rsp_valid && (r_pend_cnt != '0);
    assign w_orphan_evt    = bus.rsp_valid && (r_pend_cnt == '0);

    assign w_head_op = r_mem_op[r_rd_ptr];
    assign w_head_a  = r_mem_a[r_rd_ptr];
    assign w_head_b  = r_mem_b[r_rd_ptr];

    always_comb begin
        w_sum9  = '0;
        w_exp_r = '0;
        w_exp_c = 1'b0;
        w_exp_v = 1'b0;
        case (w_head_op)
            OP_ADD: begin
                w_sum9  = {1'b0, w_head_a} + {1'b0, w_head_b};
                w_exp_r = w_sum9[7:0];
                w_exp_c = w_sum9[8];
                w_exp_v = (w_head_a[7] == w_head_b[7]) && (w_sum9[7] != w_head_a[7]);
            end
            OP_SUB: begin
                w_sum9  = {1'b0, w_head_a} - {1'b0, w_head_b};
                w_exp_r = w_sum9[7:0];
                w_exp_c = w_sum9[8];
                w_exp_v = (w_head_a[7] != w_head_b[7]) && (w_sum9[7] != w_head_a[7]);
            end
            OP_AND:  w_exp_r = w_head_a & w_head_b;
            OP_OR:   w_exp_r = w_head_a | w_head_b;
            OP_XOR:  w_exp_r = w_head_a ^ w_head_b;
            OP_SLT:  w_exp_r = {7'b0, ($signed(w_head_a) < $signed(w_head_b))};
            OP_SLL:  w_exp_r = w_head_a << w_head_b[2:0];
            OP_SRL:  w_exp_r = w_head_a >> w_head_b[2:0];
            default: w_exp_r = '0;
        endcase
    end

    assign w_exp_z = (w_exp_r == '0);
    assign w_exp_n = w_exp_r[7];

    assign w_match = (bus.rsp_result == w_exp_r) &&
                     (bus.rsp_zero   == w_exp_z) &&
                     (bus.rsp_neg    == w_exp_n) &&
                     (bus.rsp_carry  == w_exp_c) &&
                     (bus.rsp_ovf    == w_exp_v);
    assign w_pass  = w_pop && w_match;
    assign w_fail  = w_pop && !w_match;

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_op[r_wr_ptr] <= bus.issue_op;
            r_mem_a[r_wr_ptr]  <= bus.issue_a;
            r_mem_b[r_wr_ptr]  <= bus.issue_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pend_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_pend_cnt <= r_pend_cnt + L_ONE;
                2'b01:   r_pend_cnt <= r_pend_cnt - L_ONE;
                default: r_pend_cnt <= r_pend_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
            r_err_sticky <= 1'b0;
            r_orphan     <= 1'b0;
        end else begin
            r_orphan <= w_orphan_evt;
            if (w_pass && (r_pass_cnt != '1)) r_pass_cnt <= r_pass_cnt + 1'b1;
            if (w_fail && (r_fail_cnt != '1)) r_fail_cnt <= r_fail_cnt + 1'b1;
            if (w_fail || w_orphan_evt) r_err_sticky <= 1'b1;
        end
    end

    assign pass_cnt   = r_pass_cnt;
    assign fail_cnt   = r_fail_cnt;
    assign err_sticky = r_err_sticky;
    assign orphan     = r_orphan;
    assign pend_cnt   = r_pend_cnt;

`ifdef CHK_FIRST_FAIL_EN
    logic       r_ff_valid;
    logic [3:0] r_ff_op;
    logic [7:0] r_ff_exp;
    logic [7:0] r_ff_got;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ff_valid <= 1'b0;
            r_ff_op    <= '0;
            r_ff_exp   <= '0;
            r_ff_got   <= '0;
        end else if (w_fail && !r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_op    <= w_head_op;
            r_ff_exp   <= w_exp_r;
            r_ff_got   <= bus.rsp_result;
        end
    end

    assign ff_valid = r_ff_valid;
    assign ff_op    = r_ff_op;
    assign ff_exp   = r_ff_exp;
    assign ff_got   = r_ff_got;
`else
    assign ff_valid = 1'b0;
    assign ff_op    = '0;
    assign ff_exp   = '0;
    assign ff_got   = '0;
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Self-checking bench for alu_result_checker: directed scenarios plus randomized traffic
// checked against a queue-based reference model using plain integer arithmetic.
module tb_alu_result_checker;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int PCW   = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef CHK_FIRST_FAIL_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_result_checker_if bus();

    logic [CNT_W-1:0] pass_cnt, fail_cnt;
    logic             err_sticky, orphan, ff_valid;
    logic [PCW-1:0]   pend_cnt;
    logic [3:0]       ff_op;
    logic [7:0]       ff_exp, ff_got;

    alu_result_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .err_sticky (err_sticky),
        .orphan     (orphan),
        .pend_cnt   (pend_cnt),
        .ff_valid   (ff_valid),
        .ff_op      (ff_op),
        .ff_exp     (ff_exp),
        .ff_got     (ff_got)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } ent_t;

    ent_t       mq[$];
    int         m_pass, m_fail;
    bit         m_err, m_orph, m_ffv;
    logic [3:0] m_ffop;
    logic [7:0] m_ffexp, m_ffgot;

    // Packed response: [11:4] result, [3] Z, [2] N, [1] C, [0] V.
    function automatic logic [11:0] gold(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia, ib, sa, sb, r;
        bit c, v;
        logic [7:0] res;
        ia = int'(a);
        ib = int'(b);
        sa = (ia > 127) ? ia - 256 : ia;
        sb = (ib > 127) ? ib - 256 : ib;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin r = ia + ib; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            4'd1: begin r = ia - ib; c = (r < 0);   v = (sa - sb > 127) || (sa - sb < -128); end
            4'd2: r = ia & ib;
            4'd3: r = ia | ib;
            4'd4: r = ia ^ ib;
            4'd5: r = (sa < sb) ? 1 : 0;
            4'd6: r = ia * (2 ** (ib % 8));
            4'd7: r = ia / (2 ** (ib % 8));
            default: r = 0;
        endcase
        r = ((r % 256) + 256) % 256;
        res = 8'(r);
        return {res, (r == 0), (r >= 128), c, v};
    endfunction

    function automatic logic [11:0] head_rsp(input logic [11:0] mask);
        if (mq.size() == 0) return mask;
        return gold(mq[0].op, mq[0].a, mq[0].b) ^ mask;
    endfunction

    task automatic step(input bit r, input bit iv, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input bit rv, input logic [11:0] rsp);
        ent_t e;
        logic [11:0] g;
        bit rdy;
        rst             = r;
        bus.issue_valid = iv;
        bus.issue_op    = op;
        bus.issue_a     = a;
        bus.issue_b     = b;
        bus.rsp_valid   = rv;
        bus.rsp_result  = rsp[11:4];
        bus.rsp_zero    = rsp[3];
        bus.rsp_neg     = rsp[2];
        bus.rsp_carry   = rsp[1];
        bus.rsp_ovf     = rsp[0];
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            m_pass = 0; m_fail = 0; m_err = 0; m_orph = 0; m_ffv = 0;
            m_ffop = '0; m_ffexp = '0; m_ffgot = '0;
        end else begin
            rdy = (mq.size() != DEPTH);
            m_orph = 0;
            if (rv) begin
                if (mq.size() == 0) begin
                    m_orph = 1;
                    m_err  = 1;
                end else begin
                    e = mq.pop_front();
                    g = gold(e.op, e.a, e.b);
                    if (g == rsp) begin
                        if (m_pass < CMAX) m_pass++;
                    end else begin
                        if (m_fail < CMAX) m_fail++;
                        m_err = 1;
                        if (FF_EN && !m_ffv) begin
                            m_ffv = 1; m_ffop = e.op; m_ffexp = g[11:4]; m_ffgot = rsp[11:4];
                        end
                    end
                end
            end
            if (iv && rdy) mq.push_back(ent_t'({op, a, b}));
        end
    endtask

    task automatic idle();
        step(0, 0, 4'h0, 8'h00, 8'h00, 0, 12'h000);
    endtask

    task automatic do_reset();
        step(1, 0, 4'h0, 8'h00, 8'h00, 0, 12'h000);
    endtask

    task automatic test_reset();
        step(1, 1, 4'h0, 8'h01, 8'h02, 1, 12'h030);
        checks++; if (pend_cnt !== '0) begin errors++; $display("FAIL reset_pend got=%0d exp=0", pend_cnt); end
        checks++; if (pass_cnt !== '0) begin errors++; $display("FAIL reset_pass got=%0d exp=0", pass_cnt); end
        checks++; if (fail_cnt !== '0) begin errors++; $display("FAIL reset_fail got=%0d exp=0", fail_cnt); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_sticky); end
        checks++; if (orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan got=%b exp=0", orphan); end
        checks++; if ({ff_valid, ff_op, ff_exp, ff_got} !== 21'h0) begin errors++; $display("FAIL reset_ff got=%b/%h/%h/%h exp=0", ff_valid, ff_op, ff_exp, ff_got); end
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.issue_ready); end
        idle();
        checks++; if (pend_cnt !== '0) begin errors++; $display("FAIL reset_prio_pend got=%0d exp=0", pend_cnt); end
    endtask

    task automatic test_add_pass();
        do_reset();
        step(0, 1, 4'h0, 8'h05, 8'h03, 0, 12'h000);
        checks++; if (pend_cnt !== 3'd1) begin errors++; $display("FAIL add_pend1 got=%0d exp=1", pend_cnt); end
        step(0, 0, 4'h0, 8'h00, 8'h00, 1, {8'h08, 4'b0000});
        checks++; if (pass_cnt !== 4'd1) begin errors++; $display("FAIL add_pass got=%0d exp=1", pass_cnt); end
        checks++; if (fail_cnt !== 4'd0) begin errors++; $display("FAIL add_fail got=%0d exp=0", fail_cnt); end
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL add_pend0 got=%0d exp=0", pend_cnt); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL add_err got=%b exp=0", err_sticky); end
    endtask

    task automatic test_sub_fail();
        do_reset();
        step(0, 1, 4'h1, 8'h0A, 8'h03, 0, 12'h000);
        step(0, 0, 4'h0, 8'h00, 8'h00, 1, {8'h07, 4'b0010});
        checks++; if (fail_cnt !== 4'd1) begin errors++; $display("FAIL sub_fail got=%0d exp=1", fail_cnt); end
        checks++; if (pass_cnt !== 4'd0) begin errors++; $display("FAIL sub_pass got=%0d exp=0", pass_cnt); end
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL sub_err got=%b exp=1", err_sticky); end
        checks++; if ({ff_valid, ff_op, ff_exp, ff_got} !== (FF_EN ? {1'b1, 4'h1, 8'h07, 8'h07} : 21'h0))
            begin errors++; $display("FAIL sub_ff got=%b/%h/%h/%h", ff_valid, ff_op, ff_exp, ff_got); end
        step(0, 1, 4'h2, 8'hFF, 8'h0F, 0, 12'h000);
        step(0, 0, 4'h0, 8'h00, 8'h00, 1, {8'h00, 4'b1000});
        checks++; if (fail_cnt !== 4'd2) begin errors++; $display("FAIL sub_fail2 got=%0d exp=2", fail_cnt); end
        checks++; if ({ff_valid, ff_op, ff_exp, ff_got} !== (FF_EN ? {1'b1, 4'h1, 8'h07, 8'h07} : 21'h0))
            begin errors++; $display("FAIL sub_ff_hold got=%b/%h/%h/%h", ff_valid, ff_op, ff_exp, ff_got); end
    endtask

    task automatic test_fill_order();
        do_reset();
        step(0, 1, 4'h0, 8'h7F, 8'h01, 0, 12'h000);
        step(0, 1, 4'h5, 8'h80, 8'h01, 0, 12'h000);
        step(0, 1, 4'h6, 8'h0F, 8'h02, 0, 12'h000);
        step(0, 1, 4'h7, 8'hF0, 8'h03, 0, 12'h000);
        checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b exp=0", bus.issue_ready); end
        checks++; if (pend_cnt !== 3'd4) begin errors++; $display("FAIL fill_pend got=%0d exp=4", pend_cnt); end
        step(0, 1, 4'h4, 8'h11, 8'h22, 0, 12'h000);
        checks++; if (pend_cnt !== 3'd4) begin errors++; $display("FAIL fill_drop got=%0d exp=4", pend_cnt); end
        step(0, 0, 4'h0, 8'h00, 8'h00, 1, {8'h80, 4'b0101});
        step(0, 0, 4'h0, 8'h00, 8'h00, 1, {8'h01, 4'b0000});
        step(0, 0, 4'h0, 8'h00, 8'h00, 1, {8'h3C, 4'b0000});
        step(0, 0, 4'h0, 8'h00, 8'h00, 1, {8'h1E, 4'b0000});
        checks++; if (pass_cnt !== 4'd4) begin errors++; $display("FAIL fill_pass got=%0d exp=4", pass_cnt); end
        checks++; if (fail_cnt !== 4'd0) begin errors++; $display("FAIL fill_fail got=%0d exp=0", fail_cnt); end
        checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL fill_pend0 got=%0d exp=0", pend_cnt); end
    endtask

    task automatic test_full_simul();
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(0, 1, 4'h0, 8'($urandom), 8'($urandom), 0, 12'h000);
        step(0, 1, 4'h3, 8'h12, 8'h34, 1, head_rsp(12'h000));
        checks++; if (pend_cnt !== 3'd3) begin errors++; $display("FAIL full_simul_pend got=%0d exp=3", pend_cnt); end
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL full_simul_ready got=%b exp=1", bus.issue_ready); end
        step(0, 1, 4'h3, 8'h12, 8'h34, 1, head_rsp(12'h000));
        checks++; if (pend_cnt !== 3'd3) begin errors++; $display("FAIL simul_pend got=%0d exp=3", pend_cnt); end
        checks++; if (pass_cnt !== 4'd2) begin errors++; $display("FAIL simul_pass got=%0d exp=2", pass_cnt); end
    endtask

    task automatic test_orphan();
        do_reset();
        step(0, 0, 4'h0, 8'h00, 8'h00, 1, 12'h5A5);
        checks++; if (orphan !== 1'b1) begin errors++; $display("FAIL orphan_pulse got=%b exp=1", orphan); end
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL orphan_err got=%b exp=1", err_sticky); end
        checks++; if ({pass_cnt, fail_cnt, pend_cnt} !== '0) begin errors++; $display("FAIL orphan_cnt got=%0d/%0d/%0d exp=0/0/0", pass_cnt, fail_cnt, pend_cnt); end
        idle();
        checks++; if (orphan !== 1'b0) begin errors++; $display("FAIL orphan_end got=%b exp=0", orphan); end
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL orphan_hold got=%b exp=1", err_sticky); end
        step(0, 1, 4'h0, 8'h01, 8'h01, 1, {8'h02, 4'b0000});
        checks++; if (orphan !== 1'b1) begin errors++; $display("FAIL nobypass_orphan got=%b exp=1", orphan); end
        checks++; if (pend_cnt !== 3'd1) begin errors++; $display("FAIL nobypass_pend got=%0d exp=1", pend_cnt); end
        step(0, 0, 4'h0, 8'h00, 8'h00, 1, {8'h02, 4'b0000});
        checks++; if (pass_cnt !== 4'd1) begin errors++; $display("FAIL nobypass_pass got=%0d exp=1", pass_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 4'h2, 8'($urandom), 8'($urandom), 0, 12'h000);
        do_reset();
        checks++; if ({pass_cnt, fail_cnt, pend_cnt, err_sticky, orphan} !== '0)
            begin errors++; $display("FAIL rstmid_state got=%0d/%0d/%0d/%b/%b exp=0", pass_cnt, fail_cnt, pend_cnt, err_sticky, orphan); end
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", bus.issue_ready); end
        step(0, 0, 4'h0, 8'h00, 8'h00, 1, 12'h000);
        checks++; if (orphan !== 1'b1) begin errors++; $display("FAIL rstmid_orphan got=%b exp=1", orphan); end
        checks++; if ({pass_cnt, fail_cnt} !== '0) begin errors++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", pass_cnt, fail_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        step(0, 1, 4'h0, 8'h10, 8'h20, 0, 12'h000);
        for (int i = 0; i < CMAX; i++) step(0, 1, 4'h0, 8'($urandom), 8'($urandom), 1, head_rsp(12'h010));
        checks++; if (fail_cnt !== 4'hF) begin errors++; $display("FAIL sat_reach got=%0d exp=15", fail_cnt); end
        for (int i = 0; i < 5; i++) step(0, 1, 4'h1, 8'($urandom), 8'($urandom), 1, head_rsp(12'h001));
        checks++; if (fail_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got=%0d exp=15", fail_cnt); end
        checks++; if (pass_cnt !== 4'd0) begin errors++; $display("FAIL sat_pass got=%0d exp=0", pass_cnt); end
    endtask

    task automatic test_random();
        bit r, iv, rv;
        logic [11:0] mask;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            r    = ($urandom_range(0, 99) == 0);
            iv   = ($urandom_range(0, 1) == 1);
            rv   = ($urandom_range(0, 2) != 0);
            mask = ($urandom_range(0, 4) == 0) ? (12'h001 << $urandom_range(0, 11)) : 12'h000;
            step(r, iv, 4'($urandom), 8'($urandom), 8'($urandom), rv, head_rsp(mask));
            checks++; if (pass_cnt !== CNT_W'(m_pass)) begin errors++; $display("FAIL rnd_pass n=%0d got=%0d exp=%0d", n, pass_cnt, m_pass); end
            checks++; if (fail_cnt !== CNT_W'(m_fail)) begin errors++; $display("FAIL rnd_fail n=%0d got=%0d exp=%0d", n, fail_cnt, m_fail); end
            checks++; if (pend_cnt !== PCW'(mq.size())) begin errors++; $display("FAIL rnd_pend n=%0d got=%0d exp=%0d", n, pend_cnt, mq.size()); end
            checks++; if ({err_sticky, orphan} !== {m_err, m_orph}) begin errors++; $display("FAIL rnd_flags n=%0d got=%b%b exp=%b%b", n, err_sticky, orphan, m_err, m_orph); end
            checks++; if (bus.issue_ready !== (mq.size() != DEPTH)) begin errors++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, bus.issue_ready, mq.size() != DEPTH); end
            checks++; if ({ff_valid, ff_op, ff_exp, ff_got} !== {m_ffv, m_ffop, m_ffexp, m_ffgot})
                begin errors++; $display("FAIL rnd_ff n=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", n, ff_valid, ff_op, ff_exp, ff_got, m_ffv, m_ffop, m_ffexp, m_ffgot); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.issue_valid = 1'b0; bus.issue_op = '0; bus.issue_a = '0; bus.issue_b = '0;
        bus.rsp_valid = 1'b0; bus.rsp_result = '0;
        bus.rsp_zero = 1'b0; bus.rsp_neg = 1'b0; bus.rsp_carry = 1'b0; bus.rsp_ovf = 1'b0;
        m_ffop = '0; m_ffexp = '0; m_ffgot = '0;
        test_reset();
        test_add_pass();
        test_sub_fail();
        test_fill_order();
        test_full_simul();
        test_orphan();
        test_reset_mid();
        test_saturate();
        test_random();
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
